// File: rtl/ats21_pkg.sv
// ats21_pkg
// Shared definitions for the ATS21 request issuer: instruction opcodes, opcode field
// position, issuer FSM states, the Nop instruction word and small decode helpers.
// Also imported by the bench to build instructions.
package ats21_pkg;

  typedef enum logic [2:0] {
    NOP      = 3'b000,
    SET_CLK  = 3'b001,
    TGL_BC   = 3'b010,
    SET_MODE = 3'b011,
    RSVD     = 3'b100,
    SET_ALM  = 3'b101,
    SET_CD   = 3'b110,
    TGL_AT   = 3'b111
  } ats21_opc_e;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WORD1 = 2'd1,
    S_WORD2 = 2'd2,
    S_WAIT  = 2'd3
  } ats21_state_e;

  localparam logic [31:0] ATS21_NOP = 32'h0;

  function automatic ats21_opc_e ats21_opc(input logic [31:0] instr);
    return ats21_opc_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

  // Nop and the reserved opcode are consumed at acceptance and never reach the FIFO.
  function automatic logic ats21_enq(input logic [31:0] instr);
    ats21_opc_e opc;
    opc = ats21_opc(instr);
    return (opc != NOP) && (opc != RSVD);
  endfunction

endpackage

// File: rtl/ats21_ififo.sv
// ats21_ififo
// Two-entry, 32-bit synchronous FIFO holding one client's pending instructions.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data : write request and data; ignored when full
//   i_pop          : read request; ignored when empty
//   o_data         : head entry (valid when o_count != 0)
//   o_count        : number of stored entries, 0..2
module ats21_ififo (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [31:0] o_data,
  output logic [1:0]  o_count
);

  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ats21_req_issuer.sv
// ats21_req_issuer
// Front-end for ATS21: accepts 32-bit instructions from clients A and B, filters Nop and
// reserved opcodes, buffers up to two per client and serialises A/B pairs onto the ATS21
// request bus as two 16-bit words, then waits for ats_ready (or a timeout).
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   a_valid/a_instr/a_ready     : client A handshake (ready = FIFO not full)
//   b_valid/b_instr/b_ready     : client B handshake
//   ats_ready                   : ATS21 ready input
//   req, ctrlA, ctrlB           : ATS21 request bus (registered)
//   err_a, err_b                : one-cycle pulse on reserved opcode from a client
//   timeout                     : one-cycle pulse when the wait for ats_ready expires
//   busy                        : FSM not idle
module ats21_req_issuer
  import ats21_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_instr,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_instr,
  output logic        b_ready,
  input  logic        ats_ready,
  output logic        req,
  output logic [15:0] ctrlA,
  output logic [15:0] ctrlB,
  output logic        err_a,
  output logic        err_b,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned    CntW    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);
  localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};

  ats21_state_e    r_state;
  logic            r_req;
  logic [15:0]     r_ctrl_a;
  logic [15:0]     r_ctrl_b;
  logic [15:0]     r_lo_a;
  logic [15:0]     r_lo_b;
  logic            r_err_a;
  logic            r_err_b;
  logic            r_timeout;
  logic            r_busy;
  logic [CntW-1:0] r_wait_cnt;

  logic [1:0]  w_a_count;
  logic [1:0]  w_b_count;
  logic [31:0] w_a_head;
  logic [31:0] w_b_head;
  logic        w_a_ready;
  logic        w_b_ready;
  logic        w_a_accept;
  logic        w_b_accept;
  logic        w_a_push;
  logic        w_b_push;
  logic        w_a_empty;
  logic        w_b_empty;
  logic        w_start;
  logic        w_a_pop;
  logic        w_b_pop;
  logic [31:0] w_a_issue;
  logic [31:0] w_b_issue;

  // Gated by reset so clients see not-ready for the whole reset assertion.
  assign w_a_ready = !reset && (w_a_count != 2'd2);
  assign w_b_ready = !reset && (w_b_count != 2'd2);
  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;

  assign w_a_accept = a_valid && w_a_ready;
  assign w_b_accept = b_valid && w_b_ready;
  assign w_a_push   = w_a_accept && ats21_enq(a_instr);
  assign w_b_push   = w_b_accept && ats21_enq(b_instr);

  assign w_a_empty = (w_a_count == 2'd0);
  assign w_b_empty = (w_b_count == 2'd0);

  // Both heads leave together so A and B of one transfer are never split.
  assign w_start   = (r_state == S_IDLE) && !(w_a_empty && w_b_empty);
  assign w_a_pop   = w_start && !w_a_empty;
  assign w_b_pop   = w_start && !w_b_empty;
  assign w_a_issue = w_a_empty ? ATS21_NOP : w_a_head;
  assign w_b_issue = w_b_empty ? ATS21_NOP : w_b_head;

  ats21_ififo u_fifo_a (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_a_push),
    .i_data  (a_instr),
    .i_pop   (w_a_pop),
    .o_data  (w_a_head),
    .o_count (w_a_count)
  );

  ats21_ififo u_fifo_b (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_b_push),
    .i_data  (b_instr),
    .i_pop   (w_b_pop),
    .o_data  (w_b_head),
    .o_count (w_b_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_ctrl_a   <= 16'h0;
      r_ctrl_b   <= 16'h0;
      r_lo_a     <= 16'h0;
      r_lo_b     <= 16'h0;
      r_err_a    <= 1'b0;
      r_err_b    <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_err_a   <= w_a_accept && (ats21_opc(a_instr) == RSVD);
      r_err_b   <= w_b_accept && (ats21_opc(b_instr) == RSVD);
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req    <= 1'b1;
            r_ctrl_a <= w_a_issue[31:16];
            r_ctrl_b <= w_b_issue[31:16];
            r_lo_a   <= w_a_issue[15:0];
            r_lo_b   <= w_b_issue[15:0];
            r_busy   <= 1'b1;
            r_state  <= S_WORD1;
          end
        end
        S_WORD1: begin
          r_req    <= 1'b0;
          r_ctrl_a <= r_lo_a;
          r_ctrl_b <= r_lo_b;
          r_state  <= S_WORD2;
        end
        S_WORD2: begin
          r_ctrl_a   <= 16'h0;
          r_ctrl_b   <= 16'h0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (ats_ready || (r_wait_cnt == CntLast)) begin
            r_timeout <= !ats_ready;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_wait_cnt != CntSat) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req     = r_req;
  assign ctrlA   = r_ctrl_a;
  assign ctrlB   = r_ctrl_b;
  assign err_a   = r_err_a;
  assign err_b   = r_err_b;
  assign timeout = r_timeout;
  assign busy    = r_busy;

endmodule

// File: tb/tb_ats21_req_issuer.sv
// Directed bench for ats21_req_issuer; expected values are hand-computed constants.
module tb_ats21_req_issuer;
  import ats21_pkg::*;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [31:0] a_instr;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_instr;
  logic        b_ready;
  logic        ats_ready;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        err_a;
  logic        err_b;
  logic        timeout;
  logic        busy;

  int n_checks;
  int n_errors;

  ats21_req_issuer #(.WAIT_MAX(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_instr   (a_instr),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_instr   (b_instr),
    .b_ready   (b_ready),
    .ats_ready (ats_ready),
    .req       (req),
    .ctrlA     (ctrlA),
    .ctrlB     (ctrlB),
    .err_a     (err_a),
    .err_b     (err_b),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input ats21_opc_e opc, input logic [12:0] w1,
                                     input logic [15:0] w2);
    return {opc, w1, w2};
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || req) && k < 200) begin
      tick();
      k++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] tput [4];
  int          req_at[$];
  logic [15:0] req_ctrl[$];
  int          waited;
  int          seen;
  int          adj;
  int          guard;
  logic        ok;
  logic        prev;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_instr   = 32'h0;
    b_valid   = 1'b0;
    b_instr   = 32'h0;
    ats_ready = 1'b1;
    tput[0]   = 32'h2001_0000;
    tput[1]   = 32'h4002_0000;
    tput[2]   = 32'h6003_0000;
    tput[3]   = 32'hE004_0000;

    // Reset state
    repeat (3) tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_ctrlA", 32'(ctrlA), 32'd0);
    check("rst_ctrlB", 32'(ctrlB), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'({err_a, err_b, timeout}), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    check("post_rst_b_ready", 32'(b_ready), 32'd1);

    // A alone: set_clock(0, 1X)
    a_valid = 1'b1;
    a_instr = mk(SET_CLK, 13'h0, 16'h0);
    tick();
    a_valid = 1'b0;
    check("alone_no_req_yet", 32'(req), 32'd0);
    tick();
    check("alone_w1_req", 32'(req), 32'd1);
    check("alone_w1_ctrlA", 32'(ctrlA), 32'h2000);
    check("alone_w1_ctrlB", 32'(ctrlB), 32'h0);
    check("alone_w1_busy", 32'(busy), 32'd1);
    tick();
    check("alone_w2_req", 32'(req), 32'd0);
    check("alone_w2_ctrl", 32'({ctrlA, ctrlB}), 32'h0);
    tick();
    check("alone_wait_busy", 32'(busy), 32'd1);
    tick();
    check("alone_idle_busy", 32'(busy), 32'd0);

    // Paired transfer
    a_valid = 1'b1;
    a_instr = mk(SET_ALM, 13'h0080, 16'h0100);
    b_valid = 1'b1;
    b_instr = mk(SET_ALM, 13'h1700, 16'h0100);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    check("pair_w1_req", 32'(req), 32'd1);
    check("pair_w1_ctrl", 32'({ctrlA, ctrlB}), 32'hA080_B700);
    tick();
    check("pair_w2_req", 32'(req), 32'd0);
    check("pair_w2_ctrl", 32'({ctrlA, ctrlB}), 32'h0100_0100);
    tick();
    check("pair_wait_ctrl", 32'({ctrlA, ctrlB}), 32'h0);
    tick();
    check("pair_idle_busy", 32'(busy), 32'd0);

    // Reserved opcode on A, Nop on B: neither enqueued
    a_valid = 1'b1;
    a_instr = 32'h8000_0000;
    b_valid = 1'b1;
    b_instr = 32'h0000_0000;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("rsvd_err_a", 32'(err_a), 32'd1);
    check("nop_err_b", 32'(err_b), 32'd0);
    tick();
    check("rsvd_err_a_once", 32'(err_a), 32'd0);
    seen = 0;
    repeat (4) begin
      if (req || busy) seen++;
      tick();
    end
    check("rsvd_no_req", 32'(seen), 32'd0);
    b_valid = 1'b1;
    b_instr = mk(RSVD, 13'h1fff, 16'hffff);
    tick();
    b_valid = 1'b0;
    check("rsvd_err_b", 32'({err_a, err_b}), 32'd1);
    tick();
    check("rsvd_err_b_once", 32'(err_b), 32'd0);
    check("rsvd_b_busy", 32'(busy), 32'd0);

    // Backpressure and timeout
    ats_ready = 1'b0;
    a_valid   = 1'b1;
    a_instr   = 32'h2000_0001;
    tick();
    a_instr = 32'h4000_0002;
    check("bp_ready_1", 32'(a_ready), 32'd1);
    tick();
    check("bp_w1_req", 32'(req), 32'd1);
    check("bp_w1_ctrlA", 32'(ctrlA), 32'h2000);
    a_instr = 32'h6000_0003;
    tick();
    a_valid = 1'b0;
    check("bp_full", 32'(a_ready), 32'd0);
    check("bp_w2_ctrlA", 32'(ctrlA), 32'h0001);
    tick();
    check("bp_wait_busy", 32'(busy), 32'd1);
    waited = 0;
    while (!timeout && waited < 200) begin
      tick();
      waited++;
    end
    check("bp_timeout_cycles", 32'(waited), 32'd64);
    check("bp_timeout_idle", 32'(busy), 32'd0);
    tick();
    check("bp_t2_req", 32'(req), 32'd1);
    check("bp_t2_ctrlA", 32'(ctrlA), 32'h4000);
    check("bp_timeout_pulse", 32'(timeout), 32'd0);
    check("bp_ready_again", 32'(a_ready), 32'd1);
    ats_ready = 1'b1;
    tick();
    check("bp_t2_w2", 32'(ctrlA), 32'h0002);
    repeat (3) tick();
    check("bp_t3_req", 32'(req), 32'd1);
    check("bp_t3_ctrlA", 32'(ctrlA), 32'h6000);
    wait_idle();

    // Reset during word 2
    a_valid = 1'b1;
    a_instr = 32'h2000_1111;
    tick();
    a_instr = 32'h4000_2222;
    tick();
    a_valid = 1'b0;
    check("rw2_w1_req", 32'(req), 32'd1);
    tick();
    check("rw2_w2_ctrlA", 32'(ctrlA), 32'h1111);
    reset = 1'b1;
    tick();
    check("rw2_req", 32'(req), 32'd0);
    check("rw2_ctrl", 32'({ctrlA, ctrlB}), 32'h0);
    check("rw2_busy", 32'(busy), 32'd0);
    check("rw2_ready_in_rst", 32'(a_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rw2_ready_after", 32'(a_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      tick();
      if (req || busy) seen++;
    end
    check("rw2_no_req", 32'(seen), 32'd0);

    // Throughput with ats_ready high
    ats_ready = 1'b1;
    adj       = 0;
    prev      = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          a_valid = 1'b1;
          a_instr = tput[k];
          guard   = 0;
          do begin
            ok = a_ready;
            tick();
            guard++;
          end while (!ok && guard < 50);
        end
        a_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          tick();
          if (req) begin
            req_at.push_back(i);
            req_ctrl.push_back(ctrlA);
          end
          if (req && prev) adj++;
          prev = req;
        end
      end
    join
    check("tp_req_count", 32'(req_at.size()), 32'd4);
    check("tp_no_adjacent", 32'(adj), 32'd0);
    if (req_at.size() == 4) begin
      check("tp_first_ctrl", 32'(req_ctrl[0]), 32'h2001);
      for (int k = 1; k < 4; k++) begin
        check("tp_spacing", 32'(req_at[k] - req_at[k-1]), 32'd4);
        check("tp_order", 32'(req_ctrl[k]), 32'(tput[k][31:16]));
      end
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
